// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - field slices, entry record and hazard helpers for the issue window
package esm_pkg;

    localparam int IW       = 32;
    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam logic [6:0]    OPC_LUI   = 7'b0110111;
    localparam logic [6:0]    OPC_AUIPC = 7'b0010111;
    localparam logic [IW-1:0] NOP       = '0;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] instr;
        logic          regwrite;
        logic          alusrc;
    } entry_t;

    function automatic logic [4:0] f_rd(input logic [IW-1:0] w);
        return w[RD_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [IW-1:0] w);
        return w[RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [IW-1:0] w);
        return w[RS2_LSB +: 5];
    endfunction

    // x0 is never a real dependency, so "uses" already excludes it
    function automatic logic f_uses_rs1(input entry_t e);
        return (f_rs1(e.instr) != 5'd0) && (e.instr[6:0] != OPC_LUI) && (e.instr[6:0] != OPC_AUIPC);
    endfunction

    function automatic logic f_uses_rs2(input entry_t e);
        return (f_rs2(e.instr) != 5'd0) && !e.alusrc;
    endfunction

    function automatic logic f_writes(input entry_t e);
        return e.regwrite && (f_rd(e.instr) != 5'd0);
    endfunction

    function automatic logic f_hazard(input entry_t o, input entry_t y);
        logic raw;
        logic waw;
        logic war;
        raw = f_writes(o) && ((f_uses_rs1(y) && f_rd(o.instr) == f_rs1(y.instr)) ||
                              (f_uses_rs2(y) && f_rd(o.instr) == f_rs2(y.instr)));
        waw = f_writes(o) && (f_rd(o.instr) == f_rd(y.instr));
        war = (f_rd(y.instr) != 5'd0) &&
              ((f_uses_rs1(o) && f_rs1(o.instr) == f_rd(y.instr)) ||
               (f_uses_rs2(o) && f_rs2(o.instr) == f_rd(y.instr)));
        return raw | waw | war;
    endfunction

endpackage

// File: rtl/esm_scoreboard.sv
// rtl/esm_scoreboard.sv - per-register busy down-counters with per-entry source lookups
module esm_scoreboard #(
    parameter int N   = 16,
    parameter int LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [4:0]        i_wr_rd,
    input  logic [N-1:0][4:0] i_rs1,
    input  logic [N-1:0][4:0] i_rs2,
    output logic [N-1:0]      o_rs1_busy,
    output logic [N-1:0]      o_rs2_busy
);

    localparam int CW = $clog2(LAT + 1);

    logic [CW-1:0] r_cnt [32];

    // a reload on re-issue takes priority over the running countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (i_wr_en && (i_wr_rd == 5'(r)) && (r != 0))
                    r_cnt[r] <= CW'(LAT);
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_rs1_busy[i] = (i_rs1[i] != 5'd0) && (r_cnt[i_rs1[i]] != '0);
            o_rs2_busy[i] = (i_rs2[i] != 5'd0) && (r_cnt[i_rs2[i]] != '0);
        end
    end

endmodule

// File: rtl/esm.sv
// rtl/esm.sv - out-of-order issue window: age-ordered entries, hazard pick, compaction
module esm
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16,
    parameter int LAT                   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Instruction_word_size-1:0] Instr_in,
    input  logic                             RegWrite,
    input  logic                             ALUSrc,
    output logic [Instruction_word_size-1:0] Instr_out
);

    localparam int IDXW = $clog2(bs);
    localparam int CNTW = $clog2(bs + 1);

    entry_t             r_q [bs];
    entry_t             w_nxt [bs];
    logic [CNTW-1:0]    r_cnt;
    logic [CNTW-1:0]    w_cnt_mid;
    logic [CNTW-1:0]    w_cnt_nxt;
    logic [IW-1:0]      r_out;
    logic [bs-1:0]      w_haz;
    logic [bs-1:0]      w_ready;
    logic               w_issue;
    logic [IDXW-1:0]    w_sel;
    entry_t             w_pick;
    entry_t             w_in;
    logic               w_in_valid;
    logic [bs-1:0][4:0] w_rs1;
    logic [bs-1:0][4:0] w_rs2;
    logic [bs-1:0]      w_rs1_busy;
    logic [bs-1:0]      w_rs2_busy;

    assign Instr_out  = r_out;
    assign w_in_valid = (Instr_in != '0);
    assign w_in       = '{valid: 1'b1, instr: Instr_in, regwrite: RegWrite, alusrc: ALUSrc};

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            w_rs1[i] = f_rs1(r_q[i].instr);
            w_rs2[i] = f_rs2(r_q[i].instr);
        end
    end

    esm_scoreboard #(.N(bs), .LAT(LAT)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_issue && f_writes(w_pick)),
        .i_wr_rd    (f_rd(w_pick.instr)),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy)
    );

    // entries are kept packed from slot 0 (oldest), so slot index equals age rank
    always_comb begin
        w_haz   = '0;
        w_ready = '0;
        for (int i = 0; i < bs; i++) begin
            for (int j = 0; j < bs; j++) begin
                if ((j < i) && r_q[j].valid && f_hazard(r_q[j], r_q[i])) w_haz[i] = 1'b1;
            end
            w_ready[i] = r_q[i].valid && !w_haz[i] &&
                         !(f_uses_rs1(r_q[i]) && w_rs1_busy[i]) &&
                         !(f_uses_rs2(r_q[i]) && w_rs2_busy[i]);
        end
    end

    // a full window drains its head regardless of hazards so input is never refused
    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        if (r_cnt == CNTW'(bs)) begin
            w_issue = 1'b1;
        end else begin
            for (int i = 0; i < bs; i++) begin
                if (!w_issue && w_ready[i]) begin
                    w_issue = 1'b1;
                    w_sel   = IDXW'(i);
                end
            end
        end
        w_pick = r_q[w_sel];
    end

    always_comb begin
        for (int i = 0; i < bs; i++) w_nxt[i] = r_q[i];
        for (int i = 0; i < bs - 1; i++) begin
            if (w_issue && (IDXW'(i) >= w_sel)) w_nxt[i] = r_q[i + 1];
        end
        if (w_issue) w_nxt[bs-1] = '0;
        w_cnt_mid = r_cnt - CNTW'(w_issue);
        for (int i = 0; i < bs; i++) begin
            if (w_in_valid && (CNTW'(i) == w_cnt_mid)) w_nxt[i] = w_in;
        end
        w_cnt_nxt = w_cnt_mid + CNTW'(w_in_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < bs; i++) r_q[i] <= '0;
            r_cnt <= '0;
            r_out <= NOP;
        end else begin
            for (int i = 0; i < bs; i++) r_q[i] <= w_nxt[i];
            r_cnt <= w_cnt_nxt;
            r_out <= w_issue ? w_pick.instr : NOP;
        end
    end

endmodule

// File: tb/tb_esm.sv
// tb/tb_esm.sv - randomized scoreboard bench for the esm issue window
module tb_esm;

    localparam int BS  = 16;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Instr_in = '0;
    logic        RegWrite = 1'b0;
    logic        ALUSrc = 1'b0;
    logic [31:0] Instr_out;

    esm #(.Instruction_word_size(32), .bs(BS), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .Instr_in  (Instr_in),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .Instr_out (Instr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          rw;
        bit          alu_src;
    } ment_t;

    ment_t       mq [$];
    logic [31:0] expq [$];
    int          busy_edge [32];
    int          edge_n = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_in = 0;
    int          n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int src1(input ment_t e);
        logic [6:0] opc;
        opc = e.instr[6:0];
        if (opc == 7'b0110111 || opc == 7'b0010111 || e.instr[19:15] == 5'd0) return -1;
        return int'(e.instr[19:15]);
    endfunction

    function automatic int src2(input ment_t e);
        if (e.alu_src || e.instr[24:20] == 5'd0) return -1;
        return int'(e.instr[24:20]);
    endfunction

    function automatic int dst(input ment_t e);
        return int'(e.instr[11:7]);
    endfunction

    function automatic bit m_ready(input int i);
        int s1;
        int s2;
        int rd;
        s1 = src1(mq[i]);
        s2 = src2(mq[i]);
        rd = dst(mq[i]);
        for (int j = 0; j < i; j++) begin
            if (mq[j].rw && dst(mq[j]) != 0) begin
                if (dst(mq[j]) == s1 || dst(mq[j]) == s2) return 1'b0;
                if (dst(mq[j]) == rd) return 1'b0;
            end
            if (rd != 0 && (src1(mq[j]) == rd || src2(mq[j]) == rd)) return 1'b0;
        end
        if (s1 >= 0 && edge_n - busy_edge[s1] <= LAT) return 1'b0;
        if (s2 >= 0 && edge_n - busy_edge[s2] <= LAT) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] w, input bit rw, input bit as_i);
        int          idx;
        logic [31:0] out;
        ment_t       m;
        idx = -1;
        out = '0;
        if (mq.size() == BS) idx = 0;
        else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (idx < 0 && m_ready(i)) idx = i;
            end
        end
        if (idx >= 0) begin
            out = mq[idx].instr;
            if (mq[idx].rw && dst(mq[idx]) != 0) busy_edge[dst(mq[idx])] = edge_n;
            mq.delete(idx);
        end
        if (w != 0) begin
            m.instr = w;
            m.rw = rw;
            m.alu_src = as_i;
            mq.push_back(m);
        end
        edge_n++;
        return out;
    endfunction

    task automatic model_reset();
        mq.delete();
        expq.delete();
        for (int r = 0; r < 32; r++) busy_edge[r] = -100;
        n_in = 0;
        n_out = 0;
    endtask

    task automatic step(input logic [31:0] w, input bit rw, input bit as_i);
        @(negedge clk);
        Instr_in = w;
        RegWrite = rw;
        ALUSrc = as_i;
        expq.push_back(model_step(w, rw, as_i));
        if (w != 0) n_in++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0);
    endtask

    task automatic rnd_instr(output logic [31:0] w, output bit rw, output bit as_o);
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        r   = $urandom();
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
            0: begin w = {r[31:20], rs1, 3'b000, rd, 7'h13}; rw = 1; as_o = 1; end
            1: begin w = {1'b0, r[0], 5'b0, rs2, rs1, 3'b000, rd, 7'h33}; rw = 1; as_o = 0; end
            2: begin w = {r[31:12], rd, 7'h37}; rw = 1; as_o = 1; end
            3: begin w = {r[31:12], rd, 7'h17}; rw = 1; as_o = 1; end
            default: begin w = {r[31:25], rs2, rs1, 3'b010, r[11:7], 7'h23}; rw = 0; as_o = 0; end
        endcase
    endtask

    // monitor: one expected word per driven cycle, compared just after the edge
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("issue", Instr_out, e);
                end
                if (Instr_out != 0) n_out++;
            end
        end
    end

    initial begin
        logic [31:0] w;
        bit          rw;
        bit          as_v;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", Instr_out, 32'h0);
        rst = 1'b1;

        step(32'h00A00093, 1, 1);
        step(32'h01400113, 1, 1);
        idle(4);

        step(32'h00A00093, 1, 1);
        step(32'h002081B3, 1, 0);
        step(32'h00F00713, 1, 1);
        idle(8);

        step(32'h01400113, 1, 1);
        step(32'h40A10133, 1, 0);
        idle(6);

        step(32'h00A00093, 1, 1);
        for (int k = 1; k <= 7; k++) step(32'(k << 20) | 32'h00008093, 1, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        Instr_in = '0;
        RegWrite = 1'b0;
        ALUSrc = 1'b0;
        #1;
        chk("reset_async", Instr_out, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_hold", Instr_out, 32'h0);
        rst = 1'b1;
        idle(6);

        step(32'h00A00093, 1, 1);
        for (int k = 1; k <= 23; k++) step(32'(k << 20) | 32'h00008093, 1, 1);
        idle(110);

        repeat (5) begin
            for (int i = 0; i < 20; i++) begin
                rnd_instr(w, rw, as_v);
                step(w, rw, as_v);
            end
            idle(90);
        end

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) step(32'h0, 0, 0);
            else begin
                rnd_instr(w, rw, as_v);
                step(w, rw, as_v);
            end
        end
        idle(100);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        chk("conservation", 32'(n_out), 32'(n_in));
        chk("model_empty", 32'(mq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
